// File: rtl/nios2_cpu_mul_combine_pkg.sv
// Shared types and widths for the multiplier partial-product combiner.
// Holds the partial-product/half widths, the stage entry struct and the
// combine helper used by stage B.
package nios2_cpu_mul_combine_pkg;

  localparam int PP_W      = 32;
  localparam int HALF_W    = 16;
  // Tag field is sized for the widest tag the block supports; the top
  // zero-extends its TAG_W tag into it and slices it back out.
  localparam int TAG_MAX_W = 16;

  // One pipeline entry: res holds p1 in stage A and the final result in stage B.
  typedef struct packed {
    logic [PP_W-1:0]      res;
    logic [HALF_W-1:0]    mid;
    logic [TAG_MAX_W-1:0] tag;
  } stage_t;

  // Low 32 bits of the product: p1 + (mid << 16), wrapping.
  function automatic logic [PP_W-1:0] combine(input stage_t e);
    return e.res + {e.mid, {HALF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/nios2_cpu_mul_skid.sv
// Purpose: 1-entry input skid buffer so in_ready comes straight from a flop.
// Latency: 0 cycles when empty (input passes through), 1 entry of storage.
// Backpressure: in_rdy_o is registered; it drops the cycle after the skid fills.
module nios2_cpu_mul_skid
  import nios2_cpu_mul_combine_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   flush_i,
  input  logic   in_vld_i,
  input  stage_t in_dat_i,
  output logic   in_rdy_o,
  output logic   out_vld_o,
  input  logic   out_rdy_i,
  output stage_t out_dat_o,
  output logic   held_o
);

  logic   skid_vld_q, skid_vld_d;
  logic   rdy_q, rdy_d;
  stage_t skid_dat_q, skid_dat_d;
  logic   in_fire;

  assign in_rdy_o  = rdy_q & ~flush_i;
  assign in_fire   = in_vld_i & in_rdy_o;
  // A held entry is always older than anything on the input, so it goes first.
  assign out_vld_o = skid_vld_q | in_fire;
  assign out_dat_o = skid_vld_q ? skid_dat_q : in_dat_i;
  assign held_o    = skid_vld_q;

  // Next state: capture an accepted input that downstream could not take.
  always_comb begin
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (flush_i) begin
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      if (out_rdy_i) skid_vld_d = 1'b0;
    end else if (in_fire && !out_rdy_i) begin
      skid_vld_d = 1'b1;
      skid_dat_d = in_dat_i;
    end
    rdy_d = ~skid_vld_d;
  end

  // State registers; ready stays low until the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      skid_dat_q <= skid_dat_d;
    end
  end

endmodule

// File: rtl/nios2_cpu_mul_combine.sv
// Purpose: combine lo*lo, lo*hi, hi*lo partial products into the low 32 bits of src1*src2.
// Latency: 2 cycles input->out_valid, 1/cycle; NIOS2_MUL_COMBINE_SKID_EN adds an input skid.
// Backpressure: valid/ready; capacity 2 (in_ready combinational) or 3 (in_ready registered).
module nios2_cpu_mul_combine
  import nios2_cpu_mul_combine_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      M_mul_cell_p1,
  input  logic [31:0]      M_mul_cell_p2,
  input  logic [31:0]      M_mul_cell_p3,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic [HALF_W-1:0] mid_in;
  stage_t            in_ent, s_ent;
  stage_t            a_q, a_d, b_q, b_d;
  logic              a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic              s_vld, a_adv, b_adv, held;
  logic              unused_bits;

  // Only the low halves of the cross products reach bits [31:16] of the result.
  assign mid_in = M_mul_cell_p2[HALF_W-1:0] + M_mul_cell_p3[HALF_W-1:0];
  assign in_ent = '{res: M_mul_cell_p1, mid: mid_in, tag: TAG_MAX_W'(in_tag)};

  assign b_adv = ~b_vld_q | out_ready;
  assign a_adv = ~a_vld_q | b_adv;

`ifdef NIOS2_MUL_COMBINE_SKID_EN
  logic skid_rdy;

  nios2_cpu_mul_skid u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush_i   (flush),
    .in_vld_i  (in_valid),
    .in_dat_i  (in_ent),
    .in_rdy_o  (skid_rdy),
    .out_vld_o (s_vld),
    .out_rdy_i (a_adv),
    .out_dat_o (s_ent),
    .held_o    (held)
  );

  assign in_ready = skid_rdy & reset_n;
`else
  logic rst_done_q;

  // Holds in_ready low until reset_n has been sampled high once.
  always_ff @(posedge clk) begin
    if (!reset_n) rst_done_q <= 1'b0;
    else          rst_done_q <= 1'b1;
  end

  assign in_ready = rst_done_q & reset_n & ~flush & a_adv;
  assign s_vld    = in_valid & in_ready;
  assign s_ent    = in_ent;
  assign held     = 1'b0;
`endif

  // Pipeline next state: B drains/refills from A, A refills from the input side.
  always_comb begin
    a_vld_d = a_vld_q;
    a_d     = a_q;
    b_vld_d = b_vld_q;
    b_d     = b_q;
    if (b_adv) begin
      b_vld_d = a_vld_q;
      if (a_vld_q) b_d = '{res: combine(a_q), mid: a_q.mid, tag: a_q.tag};
    end
    if (a_adv) begin
      a_vld_d = s_vld;
      if (s_vld) a_d = s_ent;
    end
    if (flush) begin
      a_vld_d = 1'b0;
      b_vld_d = 1'b0;
    end
  end

  // Stage registers; data is cleared on reset so outputs read zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      a_vld_q <= a_vld_d;
      b_vld_q <= b_vld_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Gating with reset_n keeps any output transfer out of a reset cycle.
  assign out_valid  = b_vld_q & reset_n;
  assign out_result = b_q.res;
  assign out_tag    = b_q.tag[TAG_W-1:0];
  assign busy       = a_vld_q | b_vld_q | held;

  assign unused_bits = ^{b_q.mid, b_q.tag, M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

endmodule
